// File: rtl/activation_collector_pkg.sv
// Shared definitions for the activation collector: FSM state encoding,
// integer log2, and the activation constants ACT_MAX / ONE / HALF.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Floor log2. log2(n)+1 is the number of bits needed to hold n itself.
  function automatic int log2(input int v);
    int r;
    int t;
    r = 0;
    t = v;
    while (t > 1) begin
      t = t >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Largest positive activation code.
  function automatic int act_max(input int act_w);
    return (1 << (act_w - 1)) - 1;
  endfunction

  // 1.0 in the shared fixed-point format.
  function automatic int act_one(input int frac);
    return 1 << frac;
  endfunction

  // 0.5 in the shared fixed-point format.
  function automatic int act_half(input int frac);
    return (1 << frac) / 2;
  endfunction

endpackage

// File: rtl/activation_collector_if.sv
// Handshake bundle between the neuron array / layer controller (master)
// and the activation collector (slave): layer size, neuron sums and the
// packed activation vector.
interface activation_collector_if
  import nn_pkg::*;
#(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9
);
  localparam int SIZE_W = log2(NEURON_NUM) + 1;

  logic [SIZE_W-1:0]                        layer_size;
  logic                                     layer_size_valid;
  logic                                     layer_size_ready;
  logic signed [NEURON_OUTPUT_WIDTH-1:0]    neuron_sum;
  logic                                     overflow;
  logic                                     neuron_sum_valid;
  logic                                     neuron_sum_ready;
  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]   activations;
  logic                                     activations_valid;
  logic                                     activations_ready;
  logic                                     layer_overflow;

  modport master (
    output layer_size, layer_size_valid,
    output neuron_sum, overflow, neuron_sum_valid,
    output activations_ready,
    input  layer_size_ready, neuron_sum_ready,
    input  activations, activations_valid, layer_overflow
  );

  modport slave (
    input  layer_size, layer_size_valid,
    input  neuron_sum, overflow, neuron_sum_valid,
    input  activations_ready,
    output layer_size_ready, neuron_sum_ready,
    output activations, activations_valid, layer_overflow
  );

endinterface

// File: rtl/activation_collector_activation_function.sv
// Combinational neuron-sum to activation conversion with saturation.
// Macro ACTIVATION_HARD_SIGMOID_EN selects the hard sigmoid
// clamp((x >>> 2) + HALF, 0, ONE); otherwise a clipped ReLU clamp(x, 0, ACT_MAX).
// Work is done at NEURON_OUTPUT_WIDTH+1 bits so the offset add never wraps.
module activation_function
  import nn_pkg::*;
#(
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int ACT_FRACTION        = 4
) (
  input  logic signed [NEURON_OUTPUT_WIDTH-1:0] i_sum,
  output logic signed [ACTIVATION_WIDTH-1:0]    o_act
);
  localparam int EW = NEURON_OUTPUT_WIDTH + 1;
  localparam logic signed [EW-1:0] C_ZERO = '0;

  // The hard sigmoid upper bound ONE must be a positive activation code.
  if (ACT_FRACTION > ACTIVATION_WIDTH - 2) begin : g_bad_fraction
    $error("ACT_FRACTION must not exceed ACTIVATION_WIDTH-2");
  end

  function automatic logic signed [EW-1:0] sat(input logic signed [EW-1:0] v,
                                               input logic signed [EW-1:0] lo,
                                               input logic signed [EW-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_sat;

  assign w_ext = EW'(i_sum);

`ifdef ACTIVATION_HARD_SIGMOID_EN
  localparam logic signed [EW-1:0] C_ONE  = EW'(act_one(ACT_FRACTION));
  localparam logic signed [EW-1:0] C_HALF = EW'(act_half(ACT_FRACTION));
  logic signed [EW-1:0] w_pre;

  assign w_pre = (w_ext >>> 2) + C_HALF;
  assign w_sat = sat(w_pre, C_ZERO, C_ONE);
`else
  localparam logic signed [EW-1:0] C_MAX = EW'(act_max(ACTIVATION_WIDTH));

  assign w_sat = sat(w_ext, C_ZERO, C_MAX);
`endif

  // Clamped value always fits, so the narrowing drops only sign-copy bits.
  assign o_act = ACTIVATION_WIDTH'(w_sat);

endmodule

// File: rtl/activation_collector.sv
// Activation collector: accepts one neuron sum per cycle, applies the layer
// activation (ReLU by default, hard sigmoid with ACTIVATION_HARD_SIGMOID_EN)
// and packs the results into a layer-wide vector, one vector per pass.
module activation_collector
  import nn_pkg::*;
#(
  parameter int NEURON_NUM          = 5,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int ACT_FRACTION        = 4
) (
  input logic               clk,
  input logic               rst,
  activation_collector_if.slave bus
);
  localparam int SIZE_W = log2(NEURON_NUM) + 1;
  localparam logic [SIZE_W-1:0] C_NN = SIZE_W'(NEURON_NUM);

  state_t r_state;
  state_t w_next;

  logic [SIZE_W-1:0]                  r_size;
  logic [SIZE_W-1:0]                  r_count;
  logic                               r_ovf;
  logic signed [ACTIVATION_WIDTH-1:0] r_slot [NEURON_NUM];

  logic [SIZE_W-1:0]                  w_size_clamped;
  logic signed [ACTIVATION_WIDTH-1:0] w_act;
  logic                               w_size_hs;
  logic                               w_sum_hs;
  logic                               w_out_hs;

  activation_function #(
    .NEURON_OUTPUT_WIDTH(NEURON_OUTPUT_WIDTH),
    .ACTIVATION_WIDTH   (ACTIVATION_WIDTH),
    .ACT_FRACTION       (ACT_FRACTION)
  ) u_act (
    .i_sum(bus.neuron_sum),
    .o_act(w_act)
  );

  assign w_size_clamped = (bus.layer_size > C_NN) ? C_NN : bus.layer_size;

  // Readies come from state only; handshakes qualify them with the valids.
  assign bus.layer_size_ready  = (r_state == IDLE);
  assign bus.neuron_sum_ready  = (r_state == COLLECT);
  assign bus.activations_valid = (r_state == DONE);
  assign bus.layer_overflow    = r_ovf & (r_state == DONE);

  assign w_size_hs = bus.layer_size_ready & bus.layer_size_valid;
  assign w_sum_hs  = bus.neuron_sum_ready & bus.neuron_sum_valid;
  assign w_out_hs  = bus.activations_valid & bus.activations_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: size 0 skips straight to DONE; the last sum closes the pass.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_size_hs) w_next = (w_size_clamped == '0) ? DONE : COLLECT;
      COLLECT: if (w_sum_hs && (r_count == r_size - SIZE_W'(1))) w_next = DONE;
      DONE:    if (w_out_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Size latch, slot counter, sticky overflow and slot array; an overflowed
  // sum is forced to activation 0 whatever its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_size  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < NEURON_NUM; i++) r_slot[i] <= '0;
    end else begin
      if (w_size_hs) begin
        r_size  <= w_size_clamped;
        r_count <= '0;
      end
      if (w_sum_hs) begin
        for (int i = 0; i < NEURON_NUM; i++) begin
          if (r_count == SIZE_W'(i)) r_slot[i] <= bus.overflow ? '0 : w_act;
        end
        r_ovf   <= r_ovf | bus.overflow;
        r_count <= r_count + SIZE_W'(1);
      end
      if (w_out_hs) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
        for (int i = 0; i < NEURON_NUM; i++) r_slot[i] <= '0;
      end
    end
  end

  // Pack the slots into the inputs-bus layout of the next layer.
  always_comb begin
    bus.activations = '0;
    for (int i = 0; i < NEURON_NUM; i++)
      bus.activations[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] = r_slot[i];
  end

endmodule

// File: doc/activation_collector.md
# activation_collector

Downstream stage of the neuron array. Accepts one neuron sum per cycle over a valid/ready handshake, applies the layer activation function with saturation, and packs the results into a layer-wide activation vector. The vector's format matches a neuron `inputs` bus, so the next layer pass can consume it directly. One vector is produced per layer pass; unused slots are zero.

## Interface
- NEURON_NUM, 5: maximum neurons per layer and number of vector slots
- NEURON_OUTPUT_WIDTH, 10: width of incoming signed neuron sum
- ACTIVATION_WIDTH, 9: width of each signed output activation
- ACT_FRACTION, 4: fractional bits shared by sum and activation; must be ≤ ACTIVATION_WIDTH-2
- clk  in  1  single clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- layer_size  in  log2(NEURON_NUM)+1  number of sums in this pass
- layer_size_valid  in  1
- layer_size_ready  out  1
- neuron_sum  in  NEURON_OUTPUT_WIDTH  signed sum from neuron
- overflow  in  1  overflow flag paired with neuron_sum
- neuron_sum_valid  in  1
- neuron_sum_ready  out  1
- activations  out  NEURON_NUM*ACTIVATION_WIDTH  slot i at [i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH]
- activations_valid  out  1
- activations_ready  in  1
- layer_overflow  out  1  at least one accepted sum in this vector had overflow set; valid with activations_valid

## Operation
- States:
  - IDLE: layer_size_ready=1. On a layer_size handshake, latch size and go to COLLECT. Size 0 goes to DONE with an all-zero vector. Size > NEURON_NUM is clamped to NEURON_NUM.
  - COLLECT: neuron_sum_ready=1. Each handshake writes f(sum) to slot[counter], ORs overflow into the sticky flag, and increments counter. The handshake at counter == size-1 moves to DONE.
  - DONE: activations_valid=1 and the vector is held stable. On an activations_ready handshake, clear vector, flag and counter, and go to IDLE.
- Slot mapping: the first accepted sum lands in slot 0, and so on in order. Slots ≥ size stay 0.
- Overflow handling: an accepted sum with overflow=1 writes activation 0, regardless of the sum value.
- Constants: ACT_MAX = 2^(ACTIVATION_WIDTH-1)-1, ONE = 2^ACT_FRACTION, HALF = ONE/2.
- Activation f (see Configuration) is computed at full NEURON_OUTPUT_WIDTH+1 signed precision, then clamped, then truncated to ACTIVATION_WIDTH. No wrap-around is permitted.
- Reset mid-pass: the partial vector is discarded, state returns to IDLE, all slots are zeroed.

## Timing
- Reset values:
  - layer_size_ready=1
  - neuron_sum_ready=0
  - activations=0
  - activations_valid=0
  - layer_overflow=0
- Layer_size handshake at edge N: neuron_sum_ready is high from cycle N+1.
- Throughput: one sum per cycle in COLLECT; valid gaps are tolerated.
- Last sum handshake at edge N: activations_valid is high from cycle N+1. Latency is 1 cycle.
- Ready signals depend only on state and never combinationally on any valid input.
- Inputs presented outside their accepting state are ignored and not buffered.
- Simultaneous valid on layer_size and neuron_sum in IDLE: only layer_size is accepted.
- activations_ready held high in DONE: IDLE is reached after exactly one DONE cycle.

## Configuration
- Macro ACTIVATION_HARD_SIGMOID_EN selects the activation function.
- Defined (hard sigmoid): f(x) = clamp((x >>> 2) + HALF, 0, ONE). The shift is arithmetic.
- Undefined (clipped ReLU): f(x) = 0 if x<0, ACT_MAX if x>ACT_MAX, else x.

## Structure
- Shared package nn_pkg holds:
  - log2 function
  - state encodings IDLE/COLLECT/DONE
  - ACT_MAX, ONE, HALF derivations as functions of the parameters
- Sub-module activation_function: purely combinational sum to activation, containing the macro-selected logic and clamp. It is instantiated once.
- This top level holds the FSM, counter, size latch, sticky flag and the slot register array.

## Test plan
- Reset, then no stimulus: layer_size_ready=1, all other outputs 0 for 10 cycles.
- ReLU build, size=3, sums 5, -7, 300 back-to-back: vector slots {5, 0, 255, 0, 0}, layer_overflow=0, activations_valid exactly 1 cycle after third handshake.
- Sigmoid build, size=2, sums 0 and -100: slots {8, 0}. Sums 200 and 12: slots {16, 11}.
- Size=2, second sum 100 with overflow=1: slot1=0, layer_overflow=1. The following pass with clean sums reports layer_overflow=0.
- Size=0 gives immediate DONE with all-zero vector. Size=7 with NEURON_NUM=5 accepts exactly 5 sums.
- DONE with activations_ready low for 20 cycles keeps the vector stable and neuron_sum_ready=0. Then raise rst mid-COLLECT on a following pass: outputs return to reset values next cycle.
